// File: rtl/async_arm_pkg.sv
// Shared definitions for the AsyncARM writeback stage: FSM states,
// srcDst field positions and architectural register constants.
package async_arm_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_REQ     = 3'd1,
    ST_WAIT_IN = 3'd2,
    ST_WR_RN   = 3'd3,
    ST_WAIT_RN = 3'd4,
    ST_WR_RD   = 3'd5,
    ST_WAIT_RD = 3'd6,
    ST_COMMIT  = 3'd7
  } wb_state_t;

  localparam int RD_LSB     = 12;
  localparam int RN_LSB     = 16;
  localparam int RD_WEN_BIT = 31;

  // r15 is written through the ordinary regbank path; kept here for users
  localparam logic [3:0] REG_PC = 4'd15;

  // Extract a 4-bit register specifier starting at bit position lsb
  function automatic logic [3:0] reg_field(input logic [31:0] word, input int lsb);
    return word[lsb +: 4];
  endfunction

endpackage

// File: rtl/writeback_ready_sync.sv
// Synchronizer for a self-timed ready level plus completion detection.
// done pulses for one cycle on a rising synchronized ready, but only if a
// low level has been observed since the last clear (i.e. since the request
// toggle), so a ready left high from the previous transfer never counts.
module ready_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic i_ready,
  input  logic i_clear,
  output logic o_done
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;
  logic                   r_low_seen;
  logic                   w_sync;

  assign w_sync = r_sync[SYNC_STAGES-1];
  assign o_done = w_sync & ~r_prev & r_low_seen;

  // Shift ready through the synchronizer and track low-after-request
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync     <= '0;
      r_prev     <= 1'b0;
      r_low_seen <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_ready};
      r_prev <= w_sync;
      if (i_clear) begin
        r_low_seen <= 1'b0;
      end else if (!w_sync) begin
        r_low_seen <= 1'b1;
      end else begin
        r_low_seen <= r_low_seen;
      end
    end
  end

endmodule

// File: rtl/writeback.sv
// AsyncARM writeback stage: fetches one result token from memory via a
// toggle handshake, writes Rn (base update) then Rd into regbank, and
// commits the CPSR and the retired-instruction count.
module writeback
  import async_arm_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      dataIn1,
  input  logic [31:0]      dataIn2,
  input  logic [31:0]      cpsrIn,
  input  logic [31:0]      srcDstIn,
  input  logic             wIn,
  input  logic             readyIn,
  output logic             triggerOut,
  output logic             triggerOutRB,
  output logic [3:0]       addrOutRB,
  output logic [31:0]      dataOutRB,
  input  logic             readyInRB,
  output logic [31:0]      cpsrOut,
  output logic [CNT_W-1:0] retired,
  output logic             busy
);

  wb_state_t        r_state;
  wb_state_t        w_next;

  logic             r_trig;
  logic             r_trig_rb;
  logic [3:0]       r_addr;
  logic [31:0]      r_data;
  logic [31:0]      r_cpsr_out;
  logic [CNT_W-1:0] r_retired;

  // Holding registers for the captured token
  logic [31:0]      r_d1;
  logic [31:0]      r_d2;
  logic [31:0]      r_cpsr_h;
  logic [3:0]       r_rd;
  logic [3:0]       r_rn;
  logic             r_rd_wen;

  logic             w_done_in;
  logic             w_done_rb;
  logic             w_clr_in;
  logic             w_clr_rb;
  logic             w_unused_src;

  // Only Rd, Rn and the Rd enable are meaningful in srcDstIn
  assign w_unused_src = ^{srcDstIn[30:20], srcDstIn[11:0]};

  // Each request toggle restarts low-seen tracking on its handshake port
  assign w_clr_in = (r_state == ST_REQ);
  assign w_clr_rb = (r_state == ST_WR_RN) || (r_state == ST_WR_RD);

  ready_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_in (
    .clk     (clk),
    .reset   (reset),
    .i_ready (readyIn),
    .i_clear (w_clr_in),
    .o_done  (w_done_in)
  );

  ready_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_rb (
    .clk     (clk),
    .reset   (reset),
    .i_ready (readyInRB),
    .i_clear (w_clr_rb),
    .o_done  (w_done_rb)
  );

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state decode; Rn is always written before Rd
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:    w_next = ST_REQ;
      ST_REQ:     w_next = ST_WAIT_IN;
      ST_WAIT_IN: begin
        if (w_done_in) begin
          if (wIn) begin
            w_next = ST_WR_RN;
          end else if (srcDstIn[RD_WEN_BIT]) begin
            w_next = ST_WR_RD;
          end else begin
            w_next = ST_COMMIT;
          end
        end else begin
          w_next = ST_WAIT_IN;
        end
      end
      ST_WR_RN:   w_next = ST_WAIT_RN;
      ST_WAIT_RN: begin
        if (w_done_rb) begin
          if (r_rd_wen) begin
            w_next = ST_WR_RD;
          end else begin
            w_next = ST_COMMIT;
          end
        end else begin
          w_next = ST_WAIT_RN;
        end
      end
      ST_WR_RD:   w_next = ST_WAIT_RD;
      ST_WAIT_RD: begin
        if (w_done_rb) begin
          w_next = ST_COMMIT;
        end else begin
          w_next = ST_WAIT_RD;
        end
      end
      ST_COMMIT:  w_next = ST_REQ;
      default:    w_next = ST_IDLE;
    endcase
  end

  // Token capture, regbank request issue and commit datapath
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_trig     <= 1'b0;
      r_trig_rb  <= 1'b0;
      r_addr     <= 4'd0;
      r_data     <= 32'd0;
      r_cpsr_out <= 32'd0;
      r_retired  <= '0;
      r_d1       <= 32'd0;
      r_d2       <= 32'd0;
      r_cpsr_h   <= 32'd0;
      r_rd       <= 4'd0;
      r_rn       <= 4'd0;
      r_rd_wen   <= 1'b0;
    end else begin
      case (r_state)
        ST_REQ: begin
          r_trig <= ~r_trig;
        end
        ST_WAIT_IN: begin
          if (w_done_in) begin
            r_d1     <= dataIn1;
            r_d2     <= dataIn2;
            r_cpsr_h <= cpsrIn;
            r_rd     <= reg_field(srcDstIn, RD_LSB);
            r_rn     <= reg_field(srcDstIn, RN_LSB);
            r_rd_wen <= srcDstIn[RD_WEN_BIT];
          end
        end
        ST_WR_RN: begin
          r_addr    <= r_rn;
          r_data    <= r_d2;
          r_trig_rb <= ~r_trig_rb;
        end
        ST_WR_RD: begin
          r_addr    <= r_rd;
          r_data    <= r_d1;
          r_trig_rb <= ~r_trig_rb;
        end
        ST_COMMIT: begin
          r_cpsr_out <= r_cpsr_h;
          r_retired  <= r_retired + {{(CNT_W-1){1'b0}}, 1'b1};
        end
        default: begin
        end
      endcase
    end
  end

  assign triggerOut   = r_trig;
  assign triggerOutRB = r_trig_rb;
  assign addrOutRB    = r_addr;
  assign dataOutRB    = r_data;
  assign cpsrOut      = r_cpsr_out;
  assign retired      = r_retired;
  assign busy         = (r_state != ST_IDLE);

endmodule

// File: tb/tb_writeback.sv
// Directed bench for writeback: memory and regbank responders are driven
// step by step from one initial block; expected values are hand-computed.
module tb_writeback;

  localparam int CW = 4;  // narrow counter so the wrap is reachable quickly

  logic          clk = 1'b0;
  logic          reset;
  logic [31:0]   dataIn1, dataIn2, cpsrIn, srcDstIn;
  logic          wIn, readyIn, readyInRB;
  logic          triggerOut, triggerOutRB;
  logic [3:0]    addrOutRB;
  logic [31:0]   dataOutRB, cpsrOut;
  logic [CW-1:0] retired;
  logic          busy;

  int n_cmp = 0;
  int n_bad = 0;

  writeback #(.SYNC_STAGES(2), .CNT_W(CW)) dut (
    .clk          (clk),
    .reset        (reset),
    .dataIn1      (dataIn1),
    .dataIn2      (dataIn2),
    .cpsrIn       (cpsrIn),
    .srcDstIn     (srcDstIn),
    .wIn          (wIn),
    .readyIn      (readyIn),
    .triggerOut   (triggerOut),
    .triggerOutRB (triggerOutRB),
    .addrOutRB    (addrOutRB),
    .dataOutRB    (dataOutRB),
    .readyInRB    (readyInRB),
    .cpsrOut      (cpsrOut),
    .retired      (retired),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Wait (bounded) for triggerOut to toggle
  task automatic wait_trig(input string tag);
    logic s;
    int   k;
    s = triggerOut;
    k = 0;
    while (triggerOut === s && k < 60) begin
      @(negedge clk);
      k++;
    end
    chk(tag, {31'd0, triggerOut !== s}, 32'd1);
  endtask

  // Wait (bounded) for triggerOutRB to toggle
  task automatic wait_rb(input string tag);
    logic s;
    int   k;
    s = triggerOutRB;
    k = 0;
    while (triggerOutRB === s && k < 60) begin
      @(negedge clk);
      k++;
    end
    chk(tag, {31'd0, triggerOutRB !== s}, 32'd1);
  endtask

  // Token with no register writes; FSM must be waiting with readyIn low
  task automatic compare_token(input string tag, input logic [31:0] cpsr, input logic [31:0] exp_ret);
    logic rb0;
    rb0      = triggerOutRB;
    srcDstIn = 32'h0000_7000;
    wIn      = 1'b0;
    dataIn1  = 32'hBAD0_0001;
    dataIn2  = 32'hBAD0_0002;
    cpsrIn   = cpsr;
    readyIn  = 1'b1;
    wait_trig({tag, "_req"});
    readyIn  = 1'b0;
    chk({tag, "_cpsr"}, cpsrOut, cpsr);
    chk({tag, "_retired"}, 32'(retired), exp_ret);
    chk({tag, "_no_rb"}, {31'd0, triggerOutRB}, {31'd0, rb0});
    tick(4);
  endtask

  initial begin
    reset     = 1'b0;
    readyIn   = 1'b0;
    readyInRB = 1'b1;
    dataIn1   = 32'd0;
    dataIn2   = 32'd0;
    cpsrIn    = 32'd0;
    srcDstIn  = 32'd0;
    wIn       = 1'b0;
    tick(3);

    // Reset state
    chk("rst_trig", {31'd0, triggerOut}, 32'd0);
    chk("rst_trig_rb", {31'd0, triggerOutRB}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_retired", 32'(retired), 32'd0);
    chk("rst_cpsr", cpsrOut, 32'd0);

    // Release: IDLE -> REQ -> one toggle of triggerOut
    reset = 1'b1;
    tick(1);
    chk("rel_busy", {31'd0, busy}, 32'd1);
    chk("rel_trig_pre", {31'd0, triggerOut}, 32'd0);
    tick(7);
    chk("rel_trig", {31'd0, triggerOut}, 32'd1);
    chk("rel_trig_rb", {31'd0, triggerOutRB}, 32'd0);
    chk("rel_addr", {28'd0, addrOutRB}, 32'd0);
    chk("rel_data", dataOutRB, 32'd0);
    chk("rel_cpsr", cpsrOut, 32'd0);
    chk("rel_retired", 32'(retired), 32'd0);

    // Token A: Rd=3 write only
    dataIn1  = 32'hDEAD_BEEF;
    dataIn2  = 32'h1111_1111;
    cpsrIn   = 32'h6000_0010;
    srcDstIn = 32'h8000_3000;
    wIn      = 1'b0;
    readyIn  = 1'b1;
    wait_rb("A_rb");
    chk("A_addr", {28'd0, addrOutRB}, 32'd3);
    chk("A_data", dataOutRB, 32'hDEAD_BEEF);
    dataIn1   = 32'h0BAD_BAD0;
    cpsrIn    = 32'h0000_0000;
    readyInRB = 1'b0;
    tick(5);
    chk("A_addr_hold", {28'd0, addrOutRB}, 32'd3);
    chk("A_data_hold", dataOutRB, 32'hDEAD_BEEF);
    chk("A_cpsr_early", cpsrOut, 32'd0);
    chk("A_ret_early", 32'(retired), 32'd0);
    readyInRB = 1'b1;
    wait_trig("A_next_req");
    chk("A_cpsr", cpsrOut, 32'h6000_0010);
    chk("A_retired", 32'(retired), 32'd1);
    chk("A_trig", {31'd0, triggerOut}, 32'd0);
    readyIn = 1'b0;
    tick(4);

    // Token B: load with writeback, Rn=Rd=5
    dataIn1  = 32'h0000_00AA;
    dataIn2  = 32'h0000_1004;
    cpsrIn   = 32'h2000_0000;
    srcDstIn = 32'h8005_5000;
    wIn      = 1'b1;
    readyIn  = 1'b1;
    wait_rb("B_rb1");
    chk("B_addr1", {28'd0, addrOutRB}, 32'd5);
    chk("B_data1", dataOutRB, 32'h0000_1004);
    readyInRB = 1'b0;
    tick(6);
    chk("B_no_early_rb2", {31'd0, triggerOutRB}, 32'd0);
    chk("B_data1_hold", dataOutRB, 32'h0000_1004);
    readyInRB = 1'b1;
    wait_rb("B_rb2");
    chk("B_addr2", {28'd0, addrOutRB}, 32'd5);
    chk("B_data2", dataOutRB, 32'h0000_00AA);
    readyInRB = 1'b0;
    tick(4);
    readyInRB = 1'b1;
    wait_trig("B_next_req");
    chk("B_cpsr", cpsrOut, 32'h2000_0000);
    chk("B_retired", 32'(retired), 32'd2);
    readyIn = 1'b0;
    tick(4);

    // Token C: compare, no writes
    compare_token("C", 32'h4000_0000, 32'd3);

    // Token D completes while readyIn stays high across the next toggle
    srcDstIn = 32'h0000_0000;
    wIn      = 1'b0;
    cpsrIn   = 32'h0000_0001;
    readyIn  = 1'b1;
    wait_trig("D_req");
    chk("D_retired", 32'(retired), 32'd4);
    cpsrIn = 32'h0000_0002;
    tick(10);
    chk("stale_trig", {31'd0, triggerOut}, 32'd1);
    chk("stale_cpsr", cpsrOut, 32'h0000_0001);
    chk("stale_retired", 32'(retired), 32'd4);
    readyIn = 1'b0;
    tick(4);
    readyIn = 1'b1;
    wait_trig("E_req");
    chk("E_cpsr", cpsrOut, 32'h0000_0002);
    chk("E_retired", 32'(retired), 32'd5);
    readyIn = 1'b0;
    tick(4);

    compare_token("G", 32'h0000_0003, 32'd6);

    // Token F: Rd=2 write; reset while waiting on regbank
    dataIn1  = 32'h0000_1234;
    srcDstIn = 32'h8000_2000;
    wIn      = 1'b0;
    readyIn  = 1'b1;
    wait_rb("F_rb");
    readyIn   = 1'b0;
    readyInRB = 1'b0;
    tick(3);
    chk("F_addr", {28'd0, addrOutRB}, 32'd2);
    chk("F_data", dataOutRB, 32'h0000_1234);
    chk("F_trig", {31'd0, triggerOut}, 32'd1);
    chk("F_cpsr", cpsrOut, 32'h0000_0003);
    #2;
    reset = 1'b0;
    #1;
    chk("mid_rst_trig", {31'd0, triggerOut}, 32'd0);
    chk("mid_rst_trig_rb", {31'd0, triggerOutRB}, 32'd0);
    chk("mid_rst_addr", {28'd0, addrOutRB}, 32'd0);
    chk("mid_rst_data", dataOutRB, 32'd0);
    chk("mid_rst_cpsr", cpsrOut, 32'd0);
    chk("mid_rst_retired", 32'(retired), 32'd0);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    tick(1);
    readyInRB = 1'b1;
    tick(3);
    reset = 1'b1;
    tick(4);
    chk("rerel_trig", {31'd0, triggerOut}, 32'd1);

    // Counter wrap: 15 tokens to the maximum, then one more wraps to zero
    for (int i = 1; i <= 15; i++) begin
      compare_token($sformatf("W%0d", i), 32'(i) << 24, 32'(i));
    end
    compare_token("wrap", 32'hF000_0000, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
